// File: rtl/dsram_axi_bridge_if.sv
// Memory-stage SRAM-like data port plus single-beat AXI master port of dsram_axi_bridge.
// The master modport is the bridge's view; the slave modport is the CPU/interconnect view.
interface dsram_axi_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dsram_axi_bridge.sv
// Turns each accepted SRAM-like data request into one single-beat AXI read or write,
// with at most one transaction in flight and a registered one-cycle completion pulse.
module dsram_axi_bridge #(
  parameter logic [3:0] AXI_RID = 4'd0,
  parameter logic [3:0] AXI_WID = 4'd1
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  dsram_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic        aw_done;
  logic        w_done;
  logic        data_ok_q;
  logic        accept;
  logic        aw_hs;
  logic        w_hs;
  logic        r_hs;
  logic        b_hs;
  logic        unused_resp;

  assign accept = (state == IDLE) & bus.data_req & cpu_rst_n;
  assign aw_hs  = bus.awvalid & bus.awready;
  assign w_hs   = bus.wvalid & bus.wready;
  assign r_hs   = (state == RD_R) & bus.rvalid;
  assign b_hs   = (state == WR_B) & bus.bvalid;

  assign unused_resp = ^{bus.rresp, bus.rlast, bus.bresp};

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // AW and W close independently; B is only awaited once both have been accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.data_wr ? WR_AW_W : RD_AR;
      RD_AR:   if (bus.arready) state_nxt = RD_R;
      RD_R:    if (bus.rvalid) state_nxt = IDLE;
      WR_AW_W: if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = WR_B;
      WR_B:    if (bus.bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.data_addr_ok = accept;
    bus.arvalid      = (state == RD_AR);
    bus.rready       = (state == RD_R);
    bus.awvalid      = (state == WR_AW_W) & ~aw_done;
    bus.wvalid       = (state == WR_AW_W) & ~w_done;
    bus.bready       = (state == WR_B);
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      size_q    <= 2'd0;
      wstrb_q   <= 4'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      if (accept) begin
        addr_q  <= bus.data_addr;
        wdata_q <= bus.data_wdata;
        size_q  <= bus.data_size;
        wstrb_q <= bus.data_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      data_ok_q <= r_hs | b_hs;
      if (r_hs) rdata_q <= bus.rdata;
    end
  end

  assign bus.data_data_ok = data_ok_q;
  assign bus.data_rdata   = rdata_q;

  assign bus.arid    = AXI_RID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;

  assign bus.awid    = AXI_WID;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = 2'b01;
  assign bus.wid     = AXI_WID;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wlast   = 1'b1;

endmodule

// File: tb/tb_dsram_axi_bridge.sv
// Drives directed and random transactions through dsram_axi_bridge while acting as the AXI slave,
// predicting every output cycle by cycle from the handshake delays chosen for each transaction.
module tb_dsram_axi_bridge;

  logic cpu_clk_50M = 1'b0;
  logic cpu_rst_n;
  int   checks   = 0;
  int   failures = 0;

  bit          pend_ok    = 1'b0;
  logic [31:0] last_rdata = 32'd0;

  dsram_axi_bridge_if bus ();

  dsram_axi_bridge #(.AXI_RID(4'd0), .AXI_WID(4'd1)) dut (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst_n  (cpu_rst_n),
    .bus        (bus)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic quietSlave();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = $urandom;
    bus.rresp   = 2'($urandom);
    bus.rlast   = 1'($urandom);
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'($urandom);
  endtask

  task automatic checkNoValids(input string tag);
    checkOutput({tag, " arvalid"}, bus.arvalid, 0);
    checkOutput({tag, " rready"},  bus.rready,  0);
    checkOutput({tag, " awvalid"}, bus.awvalid, 0);
    checkOutput({tag, " wvalid"},  bus.wvalid,  0);
    checkOutput({tag, " bready"},  bus.bready,  0);
  endtask

  // One idle cycle with no request: only a pending completion may show up.
  task automatic idleCycle();
    @(negedge cpu_clk_50M);
    bus.data_req = 1'b0;
    quietSlave();
    #1;
    checkOutput("idle addr_ok", bus.data_addr_ok, 0);
    checkOutput("idle data_ok", bus.data_data_ok, 32'(pend_ok));
    checkOutput("idle rdata",   bus.data_rdata,   last_rdata);
    checkNoValids("idle");
    pend_ok = 1'b0;
  endtask

  // Read: d1 = arready delay, d2 = rvalid delay. Write: d1 = awready delay, d2 = wready delay, d3 = bvalid delay.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                               input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd_val,
                               input int d1, input int d2, input int d3, input bit hold_req);
    int b_start;
    int last_c;
    b_start = 2 + ((d1 > d2) ? d1 : d2);
    last_c  = wr ? (b_start + d3) : (2 + d1 + d2);
    for (int c = 0; c <= last_c; c++) begin
      @(negedge cpu_clk_50M);
      if (c == 0) begin
        bus.data_req   = 1'b1;
        bus.data_wr    = wr;
        bus.data_addr  = addr;
        bus.data_size  = size;
        bus.data_wdata = wd;
        bus.data_wstrb = ws;
      end else begin
        bus.data_req   = hold_req;
        bus.data_wr    = 1'($urandom);
        bus.data_addr  = $urandom;
        bus.data_size  = 2'($urandom);
        bus.data_wdata = $urandom;
        bus.data_wstrb = 4'($urandom);
      end
      quietSlave();
      bus.arready = !wr && (c == 1 + d1);
      bus.rvalid  = !wr && (c == last_c);
      if (!wr && (c == last_c)) bus.rdata = rd_val;
      bus.awready = wr && (c == 1 + d1);
      bus.wready  = wr && (c == 1 + d2);
      bus.bvalid  = wr && (c == last_c);
      #1;
      checkOutput("addr_ok", bus.data_addr_ok, 32'(c == 0));
      checkOutput("data_ok", bus.data_data_ok, 32'((c == 0) && pend_ok));
      checkOutput("data_rdata", bus.data_rdata, last_rdata);
      checkOutput("arvalid", bus.arvalid, 32'(!wr && c >= 1 && c <= 1 + d1));
      checkOutput("rready",  bus.rready,  32'(!wr && c >= 2 + d1 && c <= last_c));
      checkOutput("awvalid", bus.awvalid, 32'(wr && c >= 1 && c <= 1 + d1));
      checkOutput("wvalid",  bus.wvalid,  32'(wr && c >= 1 && c <= 1 + d2));
      checkOutput("bready",  bus.bready,  32'(wr && c >= b_start && c <= last_c));
      if (!wr && c >= 1 && c <= 1 + d1) begin
        checkOutput("araddr",  bus.araddr,  addr);
        checkOutput("arsize",  bus.arsize,  {29'd0, size});
        checkOutput("arid",    bus.arid,    0);
        checkOutput("arlen",   bus.arlen,   0);
        checkOutput("arburst", bus.arburst, 1);
      end
      if (wr && c >= 1 && c <= 1 + d1) begin
        checkOutput("awaddr",  bus.awaddr,  addr);
        checkOutput("awsize",  bus.awsize,  {29'd0, size});
        checkOutput("awid",    bus.awid,    1);
        checkOutput("awlen",   bus.awlen,   0);
        checkOutput("awburst", bus.awburst, 1);
      end
      if (wr && c >= 1 && c <= 1 + d2) begin
        checkOutput("wdata", bus.wdata, wd);
        checkOutput("wstrb", bus.wstrb, {28'd0, ws});
        checkOutput("wid",   bus.wid,   1);
        checkOutput("wlast", bus.wlast, 1);
      end
      if (c == 0) pend_ok = 1'b0;
    end
    if (!wr) last_rdata = rd_val;
    pend_ok = 1'b1;
  endtask

  // Reset lands while the bridge waits in RD_R; the read must vanish without a completion.
  task automatic resetDuringRead();
    @(negedge cpu_clk_50M);
    quietSlave();
    bus.data_req  = 1'b1;
    bus.data_wr   = 1'b0;
    bus.data_addr = 32'h2000_0040;
    bus.data_size = 2'd2;
    #1;
    checkOutput("rst-rd addr_ok", bus.data_addr_ok, 1);
    checkOutput("rst-rd data_ok", bus.data_data_ok, 32'(pend_ok));
    pend_ok = 1'b0;
    @(negedge cpu_clk_50M);
    quietSlave();
    bus.data_req = 1'b0;
    bus.arready  = 1'b1;
    #1;
    checkOutput("rst-rd arvalid", bus.arvalid, 1);
    @(negedge cpu_clk_50M);
    quietSlave();
    #1;
    checkOutput("rst-rd rready", bus.rready, 1);
    @(negedge cpu_clk_50M);
    cpu_rst_n    = 1'b0;
    bus.data_req = 1'b1;
    quietSlave();
    #1;
    checkOutput("rst-rd addr_ok in reset", bus.data_addr_ok, 0);
    @(negedge cpu_clk_50M);
    cpu_rst_n    = 1'b1;
    bus.data_req = 1'b0;
    quietSlave();
    bus.rvalid   = 1'b1;
    #1;
    checkNoValids("rst-rd after");
    checkOutput("rst-rd data_ok after", bus.data_data_ok, 0);
    checkOutput("rst-rd rdata cleared", bus.data_rdata, 0);
    last_rdata = 32'd0;
    @(negedge cpu_clk_50M);
    quietSlave();
    #1;
    checkOutput("rst-rd no late data_ok", bus.data_data_ok, 0);
    checkNoValids("rst-rd idle");
  endtask

  initial begin
    cpu_rst_n      = 1'b0;
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b0;
    bus.data_addr  = 32'd0;
    bus.data_size  = 2'd0;
    bus.data_wdata = 32'd0;
    bus.data_wstrb = 4'd0;
    quietSlave();
    repeat (2) @(negedge cpu_clk_50M);
    #1;
    checkOutput("reset addr_ok", bus.data_addr_ok, 0);
    checkOutput("reset data_ok", bus.data_data_ok, 0);
    checkOutput("reset rdata",   bus.data_rdata,   0);
    checkNoValids("reset");
    @(negedge cpu_clk_50M);
    cpu_rst_n    = 1'b1;
    bus.data_req = 1'b0;

    $display("[TB] directed transactions");
    applyStimulus(1'b0, 32'h1000_0004, 2'd2, 32'd0, 4'd0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    idleCycle();
    applyStimulus(1'b0, 32'h1000_0100, 2'd1, 32'd0, 4'd0, 32'h1234_5678, 3, 2, 0, 1'b1);
    idleCycle();
    applyStimulus(1'b1, 32'h0000_0013, 2'd0, 32'hA5A5_A5A5, 4'b0001, 32'd0, 0, 0, 1, 1'b0);
    idleCycle();
    applyStimulus(1'b1, 32'h0000_0020, 2'd2, 32'h0BAD_F00D, 4'b1111, 32'd0, 2, 0, 0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0024, 2'd2, 32'hCAFE_0001, 4'b1111, 32'd0, 0, 2, 2, 1'b1);
    applyStimulus(1'b1, 32'h0000_0028, 2'd1, 32'h5555_AAAA, 4'b1100, 32'd0, 1, 1, 0, 1'b1);
    applyStimulus(1'b0, 32'h0000_0030, 2'd2, 32'd0, 4'd0, 32'h0F0F_F0F0, 0, 0, 0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0034, 2'd2, 32'h7777_8888, 4'b1111, 32'd0, 0, 0, 0, 1'b1);
    idleCycle();

    $display("[TB] reset during read");
    resetDuringRead();
    applyStimulus(1'b0, 32'h3000_0008, 2'd3, 32'd0, 4'd0, 32'h600D_CAFE, 1, 0, 0, 1'b0);
    idleCycle();

    $display("[TB] random transactions");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom), $urandom, 2'($urandom), $urandom, 4'($urandom), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idleCycle();
    end
    idleCycle();
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
